alu_md_arbiter: RTL and testbench
=================================

// Module: alu_md_arbiter
// PURPOSE
//  Shares one multi-cycle alu_mul_div unit (instantiated inside) between two requesters, e.g. two
//  execute pipes. Round-robin grant, operand/op hold for the whole computation, flush abort, div-by-0
//  bypass, registered per-port results.
// PARAMETERS
//  RW          `RW (16)  operand/result width, from config.v
//  DIV0_BYPASS 1         1: div/mod by zero answered without the unit; 0: sent to the unit as-is
// PORTS
//  i_clk           in   1   clock; single clock domain
//  i_rst           in   1   synchronous, active-high reset; also drives u_md.i_rst
//  i_req0/i_req1   in   1   request; held high until ack
//  i_op0/i_op1     in   2   00 mul, 01 div (a/b), 10 mod (a%b), 11 reserved
//  i_a0/i_a1       in   RW  operand a; sampled at ack only
//  i_b0/i_b1       in   RW  operand b; sampled at ack only
//  i_flush0/1      in   1   abort that port's outstanding op
//  o_ack0/o_ack1   out  1   1-cycle pulse: request accepted, operands captured
//  o_rvalid0/1     out  1   1-cycle pulse: o_rdata0/1 valid
//  o_rdata0/1      out  RW  result; holds last value between pulses
//  o_busy          out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, rr pointer=0, all acks/rvalids 0, rdata 0, operand regs 0, o_busy 0.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  - IDLE: if any req and no flush on that port -> grant. Both req: port = rr pointer; rr <- other.
//    Single req: grant it; rr <- other port. Grant cycle A: o_ackN=1; op/a/b/owner registered.
//    Op 11: ack, rvalid at A+1, rdata 0, stay IDLE.
//    Div/mod with b==0 and DIV0_BYPASS: rvalid at A+1, div rdata all-ones, mod rdata = a, stay IDLE.
//    Otherwise -> ISSUE.
//  - ISSUE (cycle T=A+1): u_md.i_submit=1; mul/div/mod strobes from held op -> WAIT.
//  - WAIT: ignore o_busy on the first WAIT cycle (submit just taken); afterwards, on o_busy==0,
//    register u_md.o_d into owner's rdata; pulse rvalid next cycle; -> IDLE.
//    Op strobes and operands stay held in WAIT: the unit reads i_a/i_b/i_mod live.
//    Latency, ack->rvalid: mul A+18, div/mod A+19 (unit busy T..T+15 mul, T..T+16 div).
//  - The rvalid cycle coincides with IDLE: a new grant in that same cycle is legal
//    (back-to-back throughput).
//  - Requests arriving outside IDLE: no ack; the requester keeps waiting.
//  - Flush: i_flushN while port N owns the op in ISSUE/WAIT -> u_md.i_flush=1 that cycle
//    (combinational); -> IDLE next cycle; no rvalid; rdata unchanged.
//    Flush of the non-owner: no effect on the op. Flush with own req in IDLE: no grant, the other
//    port may be granted. Flush in the capture cycle: result dropped.
//  - Reset mid-op: all state cleared; the unit is cleared by the shared i_rst; no rvalid issued.
//  - Arithmetic: unsigned, RW bits; mul result truncated to low RW bits (unit behaviour).
// STRUCTURE
//  - Shared config.v defines: `MD_OP_MUL/`MD_OP_DIV/`MD_OP_MOD/`MD_OP_RSV (2-bit) and FSM state
//    localparams (IDLE/ISSUE/WAIT).
//  - One sub-module: alu_mul_div instance u_md; everything else in this file (FSM, rr pointer,
//    operand/result regs).
// TESTING
//  1 Port0 mul a=300 b=7 alone -> ack0 at A, rvalid0 at A+18, rdata0=2100; port1 outputs quiet.
//  2 Port0 div 1000/7 and port1 mod 1000%7 both requested at A, rr=0 -> ack0 at A, rdata0=142 at A+19;
//    ack1 on the rvalid0 cycle, rdata1=6 at +19 later.
//  3 Div 5/0, DIV0_BYPASS=1 -> rvalid at A+1, rdata 0xFFFF; mod 5%0 -> rdata 5; o_busy stays 0.
//  4 Port1 mul, i_flush1 at A+6 -> u_md.i_flush at A+6, IDLE at A+7, no rvalid1; a fresh port0 op
//    afterwards gives the correct result.
//  5 i_flush0 during port1's op -> no effect; rvalid1 on schedule. Mul 0xFFFF*0xFFFF -> 0x0001.
//  6 i_rst at WAIT cycle A+10 -> next cycle o_busy=0 and rvalid 0; the next request completes normally.

Source files
------------

// File: rtl/alu_md_arbiter_pkg.sv
// Shared definitions for the alu_md_arbiter slice: op encodings, arbiter FSM
// states and the busy lengths of the multi-cycle unit.
package alu_md_arbiter_pkg;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_OP_MUL = 2'b00;
  localparam md_op_t MD_OP_DIV = 2'b01;
  localparam md_op_t MD_OP_MOD = 2'b10;
  localparam md_op_t MD_OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Cycles o_busy stays high after the submit edge.
  localparam int MUL_BUSY = 15;
  localparam int DIV_BUSY = 16;

  function automatic logic is_divmod(input md_op_t op);
    return (op == MD_OP_DIV) || (op == MD_OP_MOD);
  endfunction

endpackage

// File: rtl/alu_md_arbiter_mul_div.sv
// alu_mul_div: multi-cycle unsigned multiply / divide / modulo unit.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_submit              start an op when idle (needs one of i_mul/i_div/i_mod)
//   i_mul/i_div/i_mod     op strobes; i_mod is read live at completion
//   i_flush               abort the running op
//   i_a, i_b              operands, read live at completion
//   o_busy                op in progress
//   o_d                   result, updated on the last busy cycle
module alu_mul_div
  import alu_md_arbiter_pkg::*;
#(
  parameter int RW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_submit,
  input  logic          i_mul,
  input  logic          i_div,
  input  logic          i_mod,
  input  logic          i_flush,
  input  logic [RW-1:0] i_a,
  input  logic [RW-1:0] i_b,
  output logic          o_busy,
  output logic [RW-1:0] o_d
);

  logic [4:0] cnt;
  logic       mul_q;

  // Product truncated to RW bits; x/0 gives all-ones and x%0 gives x.
  function automatic logic [RW-1:0] md_result(input logic mul, input logic mod,
                                               input logic [RW-1:0] a,
                                               input logic [RW-1:0] b);
    logic [2*RW-1:0] prod;
    prod = {{RW{1'b0}}, a} * {{RW{1'b0}}, b};
    if (mul) return prod[RW-1:0];
    if (b == '0) return mod ? a : '1;
    return mod ? (a % b) : (a / b);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      mul_q <= 1'b0;
    end else if (i_flush) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      if (i_submit && (i_mul || i_div || i_mod)) begin
        cnt   <= i_mul ? 5'(MUL_BUSY) : 5'(DIV_BUSY);
        mul_q <= i_mul;
      end
    end else begin
      cnt <= cnt - 5'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_flush && cnt == 5'd1) o_d <= md_result(mul_q, i_mod, i_a, i_b);
  end

  assign o_busy = (cnt != '0);

endmodule

// File: rtl/alu_md_arbiter.sv
// alu_md_arbiter: shares one alu_mul_div between two requesters.
// Round-robin grant, operands held for the whole computation, per-port flush,
// optional divide-by-zero bypass, registered per-port results.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_reqN, i_opN, i_aN, i_bN    request + op/operands (sampled at ack)
//   i_flushN                     abort port N's outstanding op
//   o_ackN                       grant pulse (combinational, IDLE only)
//   o_rvalidN, o_rdataN          result pulse and held result
//   o_busy                       arbiter not idle
module alu_md_arbiter
  import alu_md_arbiter_pkg::*;
#(
  parameter int RW          = 16,
  parameter bit DIV0_BYPASS = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic [1:0]    i_op0,
  input  logic [1:0]    i_op1,
  input  logic [RW-1:0] i_a0,
  input  logic [RW-1:0] i_a1,
  input  logic [RW-1:0] i_b0,
  input  logic [RW-1:0] i_b1,
  input  logic          i_flush0,
  input  logic          i_flush1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [RW-1:0] o_rdata0,
  output logic [RW-1:0] o_rdata1,
  output logic          o_busy
);

  arb_state_t    state, state_nx;
  logic          rr, owner, wait_first;
  md_op_t        op_q;
  logic [RW-1:0] a_q, b_q;

  logic          elig0, elig1, gnt_valid, gnt_port, g_quick, own_flush, capture;
  md_op_t        g_op;
  logic [RW-1:0] g_a, g_b, g_quick_d;
  logic          md_busy, md_flush, md_submit;
  logic [RW-1:0] md_d;

  // A port asking to flush in the same cycle is not eligible for a grant.
  assign elig0     = i_req0 && !i_flush0;
  assign elig1     = i_req1 && !i_flush1;
  assign gnt_valid = !i_rst && (state == ST_IDLE) && (elig0 || elig1);
  assign gnt_port  = (elig0 && elig1) ? rr : elig1;
  assign o_ack0    = gnt_valid && !gnt_port;
  assign o_ack1    = gnt_valid && gnt_port;

  assign g_op = gnt_port ? i_op1 : i_op0;
  assign g_a  = gnt_port ? i_a1  : i_a0;
  assign g_b  = gnt_port ? i_b1  : i_b0;

  // Ops answered directly from the grant cycle, without the unit.
  assign g_quick   = (g_op == MD_OP_RSV) || (DIV0_BYPASS && is_divmod(g_op) && (g_b == '0));
  assign g_quick_d = (g_op == MD_OP_RSV) ? '0 : ((g_op == MD_OP_DIV) ? '1 : g_a);

  assign own_flush = owner ? i_flush1 : i_flush0;
  assign md_flush  = (state != ST_IDLE) && own_flush;
  assign md_submit = (state == ST_ISSUE);
  // The first WAIT cycle's busy is not trusted: the submit has only just landed.
  assign capture   = (state == ST_WAIT) && !wait_first && !md_busy && !own_flush;
  assign o_busy    = (state != ST_IDLE);

  alu_mul_div #(.RW(RW)) u_md (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_submit(md_submit),
    .i_mul   ((state != ST_IDLE) && (op_q == MD_OP_MUL)),
    .i_div   ((state != ST_IDLE) && (op_q == MD_OP_DIV)),
    .i_mod   ((state != ST_IDLE) && (op_q == MD_OP_MOD)),
    .i_flush (md_flush),
    .i_a     (a_q),
    .i_b     (b_q),
    .o_busy  (md_busy),
    .o_d     (md_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (gnt_valid && !g_quick) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (own_flush || (!wait_first && !md_busy)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (md_flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr         <= 1'b0;
      owner      <= 1'b0;
      wait_first <= 1'b0;
      op_q       <= MD_OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      o_rdata0   <= '0;
      o_rdata1   <= '0;
    end else begin
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      wait_first <= (state == ST_ISSUE);
      if (gnt_valid) begin
        owner <= gnt_port;
        rr    <= !gnt_port;
        op_q  <= g_op;
        a_q   <= g_a;
        b_q   <= g_b;
        if (g_quick) begin
          if (gnt_port) begin o_rdata1 <= g_quick_d; o_rvalid1 <= 1'b1; end
          else          begin o_rdata0 <= g_quick_d; o_rvalid0 <= 1'b1; end
        end
      end
      if (capture) begin
        if (owner) begin o_rdata1 <= md_d; o_rvalid1 <= 1'b1; end
        else       begin o_rdata0 <= md_d; o_rvalid0 <= 1'b1; end
      end
    end
  end

endmodule

// File: tb/tb_alu_md_arbiter.sv
// Testbench for alu_md_arbiter: directed scenarios plus randomized ops,
// results and latencies derived from a plain arithmetic reference model.
module tb_alu_md_arbiter;
  import alu_md_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, flush0, flush1;
  logic [1:0]  op0, op1;
  logic [15:0] a0, a1, b0, b1;
  logic        ack0, ack1, rv0, rv1, busy;
  logic [15:0] rd0, rd1;

  int checks   = 0;
  int failures = 0;

  alu_md_arbiter #(.RW(16), .DIV0_BYPASS(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_op0(op0), .i_op1(op1),
    .i_a0(a0), .i_a1(a1), .i_b0(b0), .i_b1(b1),
    .i_flush0(flush0), .i_flush1(flush1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rvalid0(rv0), .o_rvalid1(rv1),
    .o_rdata0(rd0), .o_rdata1(rd1), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    longint unsigned pa, pb;
    pa = a; pb = b;
    case (op)
      2'b00:   return 16'((pa * pb) % 65536);
      2'b01:   return (b == 0) ? 16'hFFFF : 16'(pa / pb);
      2'b10:   return (b == 0) ? a : 16'(pa % pb);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [15:0] b);
    if (op == 2'b11) return 1;
    if (op != 2'b00 && b == 0) return 1;
    return (op == 2'b00) ? 18 : 19;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input bit p, input logic r, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b);
    if (p) begin req1 = r; op1 = op; a1 = a; b1 = b; end
    else   begin req0 = r; op0 = op; a0 = a; b0 = b; end
  endtask

  task automatic scramble(input bit p);
    set_port(p, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic set_flush(input bit p, input logic f);
    if (p) flush1 = f; else flush0 = f;
  endtask

  // One op on port p; optionally pulses the other port's flush at A+flush_k.
  task automatic do_op(input bit p, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int flush_k, input string tag);
    logic [15:0] exp_d, got;
    int exp_lat, n, lat, noise;
    exp_d = ref_res(op, a, b);
    exp_lat = ref_lat(op, b);
    lat = -1; noise = 0; got = '0;
    @(negedge clk);
    set_port(p, 1'b1, op, a, b);
    #1;
    n = 0;
    while (((p ? ack1 : ack0) !== 1'b1) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, ".ack"}, p ? ack1 : ack0, 1);
    chk({tag, ".idle_busy"}, busy, 0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) scramble(p);
      if (flush_k > 0 && k == flush_k) set_flush(!p, 1'b1);
      if (flush_k > 0 && k == flush_k + 1) set_flush(!p, 1'b0);
      #1;
      if (k == 1) chk({tag, ".busy"}, busy, (exp_lat > 1) ? 1 : 0);
      if ((p ? rv0 : rv1) === 1'b1) noise++;
      if ((p ? rv1 : rv0) === 1'b1) begin
        lat = k; got = p ? rd1 : rd0;
        break;
      end
    end
    set_flush(!p, 1'b0);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".rdata"}, got, exp_d);
    chk({tag, ".other_quiet"}, noise, 0);
  endtask

  initial begin
    logic [15:0] held, got;
    int lat, early, noise;
    logic ackx;

    rst = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
    set_port(0, 1'b1, MD_OP_MUL, 16'd3, 16'd4);
    set_port(1, 1'b0, MD_OP_MUL, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset.ack0", ack0, 0);
    chk("reset.busy", busy, 0);
    chk("reset.rv", {rv1, rv0}, 0);
    chk("reset.rdata", {rd1, rd0}, 0);
    @(negedge clk);
    rst = 1'b0;
    set_port(0, 1'b0, MD_OP_MUL, 16'd0, 16'd0);

    do_op(0, MD_OP_MUL, 16'd300, 16'd7, 0, "t1_mul");
    do_op(1, MD_OP_MUL, 16'hFFFF, 16'hFFFF, 5, "t5_mul_flush_other");

    // Both ports request at once with rr=0.
    @(negedge clk);
    set_port(0, 1'b1, MD_OP_DIV, 16'd1000, 16'd7);
    set_port(1, 1'b1, MD_OP_MOD, 16'd1000, 16'd7);
    #1;
    chk("t2.ack0", ack0, 1);
    chk("t2.ack1_first", ack1, 0);
    lat = -1; early = 0; got = '0; ackx = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) scramble(0);
      #1;
      if (rv0 === 1'b1) begin lat = k; got = rd0; ackx = ack1; break; end
      if (ack1 === 1'b1) early++;
    end
    chk("t2.lat0", lat, 19);
    chk("t2.rdata0", got, 16'd142);
    chk("t2.ack1_on_rvalid0", ackx, 1);
    chk("t2.ack1_early", early, 0);
    lat = -1; got = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) set_port(1, 1'b0, MD_OP_MUL, 16'd0, 16'd0);
      #1;
      if (rv1 === 1'b1) begin lat = k; got = rd1; break; end
    end
    chk("t2.lat1", lat, 19);
    chk("t2.rdata1", got, 16'd6);
    chk("t2.rdata0_held", rd0, 16'd142);

    // Round-robin alternation with reserved ops.
    @(negedge clk);
    set_port(0, 1'b1, MD_OP_RSV, 16'd1, 16'd1);
    set_port(1, 1'b1, MD_OP_RSV, 16'd2, 16'd2);
    #1;
    chk("rr.a_ack", {ack1, ack0}, 2'b01);
    @(negedge clk); #1;
    chk("rr.b_ack", {ack1, ack0}, 2'b10);
    chk("rr.b_rv0", rv0, 1);
    chk("rr.b_rsv_rdata0", rd0, 0);
    @(negedge clk);
    set_port(1, 1'b0, MD_OP_RSV, 16'd0, 16'd0);
    #1;
    chk("rr.c_ack", {ack1, ack0}, 2'b01);
    chk("rr.c_rv1", rv1, 1);
    @(negedge clk);
    set_port(0, 1'b0, MD_OP_RSV, 16'd0, 16'd0);
    #1;
    chk("rr.d_rv0", rv0, 1);

    // Flush on a port's own request in IDLE blocks only that port.
    @(negedge clk);
    set_port(0, 1'b1, MD_OP_RSV, 16'd1, 16'd1);
    set_port(1, 1'b1, MD_OP_RSV, 16'd1, 16'd1);
    flush0 = 1'b1;
    #1;
    chk("idle_flush.ack", {ack1, ack0}, 2'b10);
    @(negedge clk);
    set_port(0, 1'b0, MD_OP_RSV, 16'd0, 16'd0);
    set_port(1, 1'b0, MD_OP_RSV, 16'd0, 16'd0);
    flush0 = 1'b0;
    #1;
    chk("idle_flush.rv", {rv1, rv0}, 2'b10);

    do_op(0, MD_OP_DIV, 16'd5, 16'd0, 0, "t3_div0");
    do_op(1, MD_OP_MOD, 16'd5, 16'd0, 0, "t3_mod0");

    // Owner flush mid-op.
    held = rd1;
    @(negedge clk);
    set_port(1, 1'b1, MD_OP_MUL, 16'd123, 16'd45);
    #1;
    chk("t4.ack1", ack1, 1);
    noise = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) scramble(1);
      flush1 = (k == 6);
      #1;
      if (k == 6) chk("t4.md_flush", dut.u_md.i_flush, 1);
      if (k == 7) chk("t4.idle", busy, 0);
      if (rv1 === 1'b1 || rv0 === 1'b1) noise++;
    end
    chk("t4.no_rvalid", noise, 0);
    chk("t4.rdata1_held", rd1, held);
    do_op(0, MD_OP_MUL, 16'd77, 16'd91, 0, "t4_fresh");

    // Reset in the middle of an op.
    @(negedge clk);
    set_port(0, 1'b1, MD_OP_DIV, 16'd9999, 16'd3);
    #1;
    chk("t6.ack0", ack0, 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) scramble(0);
      rst = (k == 10);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6.busy_after_rst", busy, 0);
    chk("t6.rv_after_rst", {rv1, rv0}, 0);
    noise = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk); #1;
      if (rv0 === 1'b1 || rv1 === 1'b1) noise++;
    end
    chk("t6.no_rvalid", noise, 0);
    do_op(0, MD_OP_DIV, 16'd9999, 16'd3, 0, "t6_after");

    for (int i = 0; i < 10; i++) begin
      bit p;
      logic [1:0] op;
      logic [15:0] a, b;
      p  = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      do_op(p, op, a, b, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
